// File: rtl/led_frame_shifter.sv
// Frame-periodic serialiser for a daisy-chained LED driver: fetches one word per channel,
// shifts it MSB first on o_clk/o_dai, then pulses o_lat.
//   IDLE  | waiting for a frame tick
//   FETCH | o_rd_en strobe for channel r_index
//   LOAD  | capture i_rd_data into the shift register
//   SHIFT | clock out BIT_WIDTH bits, each 2*CLK_DIV cycles
//   LATCH | o_lat high for LATCH_CYCLES
module led_frame_shifter #(
  parameter int N_CHANNELS   = 12,
  parameter int BIT_WIDTH    = 16,
  parameter int FRAME_PERIOD = 16666,
  parameter int FRAME_MAX    = 120,
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 8,
  localparam int ADDR_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
  localparam int FC_W   = $clog2(FRAME_MAX)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  output logic                 o_rd_en,
  output logic [ADDR_W-1:0]    o_rd_addr,
  input  logic [BIT_WIDTH-1:0] i_rd_data,
  output logic                 o_clk,
  output logic                 o_dai,
  output logic                 o_lat,
  output logic                 o_busy,
  output logic [FC_W-1:0]      o_frame_count,
  output logic                 o_overrun
);

  localparam int PER_W = $clog2(FRAME_PERIOD);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
  localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_LATCH = 3'd4
  } state_t;

  state_t               r_state;
  logic [PER_W-1:0]     r_per;
  logic [FC_W-1:0]      r_fc;
  logic [ADDR_W-1:0]    r_index;
  logic [BIT_WIDTH-1:0] r_sreg;
  logic [DIV_W-1:0]     r_div;
  logic [BIT_W-1:0]     r_bit;
  logic [LAT_W-1:0]     r_lat_cnt;
  logic                 r_high;
  logic                 r_oclk;
  logic                 r_dai;
  logic                 r_lat;
  logic                 r_rd_en;
  logic                 r_overrun;

  logic                 w_per_last;
  logic                 w_tick;
  logic [BIT_WIDTH-1:0] w_sreg_shl;

  assign w_per_last = (r_per == PER_W'(FRAME_PERIOD - 1));
  assign w_tick     = w_per_last & i_enable;
  assign w_sreg_shl = r_sreg << 1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_per     <= '0;
      r_fc      <= '0;
      r_index   <= '0;
      r_sreg    <= '0;
      r_div     <= '0;
      r_bit     <= '0;
      r_lat_cnt <= '0;
      r_high    <= 1'b0;
      r_oclk    <= 1'b0;
      r_dai     <= 1'b0;
      r_lat     <= 1'b0;
      r_rd_en   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_per     <= w_per_last ? '0 : r_per + 1'b1;
      // The final LATCH cycle is still busy, so a tick landing there is dropped too.
      r_overrun <= w_tick && (r_state != ST_IDLE);

      case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            r_state <= ST_FETCH;
            r_index <= '0;
            r_rd_en <= 1'b1;
            r_fc    <= (r_fc == FC_W'(FRAME_MAX - 1)) ? '0 : r_fc + 1'b1;
          end
        end
        ST_FETCH: begin
          r_rd_en <= 1'b0;
          r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_sreg  <= i_rd_data;
          r_dai   <= i_rd_data[BIT_WIDTH-1];
          r_oclk  <= 1'b0;
          r_high  <= 1'b0;
          r_div   <= DIV_W'(CLK_DIV - 1);
          r_bit   <= BIT_W'(BIT_WIDTH - 1);
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (r_div != '0) begin
            r_div <= r_div - 1'b1;
          end else if (!r_high) begin
            r_high <= 1'b1;
            r_oclk <= 1'b1;
            r_div  <= DIV_W'(CLK_DIV - 1);
          end else if (r_bit != '0) begin
            r_bit  <= r_bit - 1'b1;
            r_sreg <= w_sreg_shl;
            r_dai  <= w_sreg_shl[BIT_WIDTH-1];
            r_oclk <= 1'b0;
            r_high <= 1'b0;
            r_div  <= DIV_W'(CLK_DIV - 1);
          end else begin
            r_oclk <= 1'b0;
            r_dai  <= 1'b0;
            r_high <= 1'b0;
            if (r_index != ADDR_W'(N_CHANNELS - 1)) begin
              r_index <= r_index + 1'b1;
              r_rd_en <= 1'b1;
              r_state <= ST_FETCH;
            end else begin
              r_lat     <= 1'b1;
              r_lat_cnt <= LAT_W'(LATCH_CYCLES - 1);
              r_state   <= ST_LATCH;
            end
          end
        end
        ST_LATCH: begin
          if (r_lat_cnt == '0) begin
            r_lat   <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rd_en       = r_rd_en;
  assign o_rd_addr     = r_index;
  assign o_clk         = r_oclk;
  assign o_dai         = r_dai;
  assign o_lat         = r_lat;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_frame_count = r_fc;
  assign o_overrun     = r_overrun;

endmodule

// File: doc/led_frame_shifter.md
LED_FRAME_SHIFTER -- requirements
Module: led_frame_shifter

Interface
REQ-001 SHALL have parameter N_CHANNELS, default 12: channels shifted per frame, >=1.
REQ-002 SHALL have parameter BIT_WIDTH, default 16: bits per channel word, >=1.
REQ-003 SHALL have parameter FRAME_PERIOD, default 16666: i_clk cycles per frame tick, >=2.
REQ-004 SHALL have parameter FRAME_MAX, default 120: frame counter modulus, >=2.
REQ-005 SHALL have parameter CLK_DIV, default 4: i_clk cycles per o_clk half-period, >=1.
REQ-006 SHALL have parameter LATCH_CYCLES, default 8: o_lat high duration in cycles, >=1.
REQ-007 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-008 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL have port i_enable  input  1  gates frame ticks; sampled each cycle.
REQ-010 SHALL have port o_rd_en  output  1  one-cycle channel-data read strobe.
REQ-011 SHALL have port o_rd_addr  output  clog2(N_CHANNELS) (min 1)  channel index being read.
REQ-012 SHALL have port i_rd_data  input  BIT_WIDTH  channel word, valid exactly one cycle after o_rd_en.
REQ-013 SHALL have port o_clk  output  1  serial clock to LED driver.
REQ-014 SHALL have port o_dai  output  1  serial data to LED driver.
REQ-015 SHALL have port o_lat  output  1  latch strobe to LED driver.
REQ-016 SHALL have port o_busy  output  1  high whenever FSM not IDLE.
REQ-017 SHALL have port o_frame_count  output  clog2(FRAME_MAX)  frames started, modulo FRAME_MAX.
REQ-018 SHALL have port o_overrun  output  1  one-cycle pulse on a dropped tick.

Function
REQ-019 SHALL run a period counter 0..FRAME_PERIOD-1 wrapping to 0, free-running regardless of i_enable.
REQ-020 SHALL generate tick in the cycle the period counter equals FRAME_PERIOD-1 and i_enable=1.
REQ-021 SHALL implement states IDLE, FETCH, LOAD, SHIFT, LATCH.
REQ-022 IDLE: on tick -> FETCH with channel index 0; o_frame_count increments, wrapping FRAME_MAX-1 -> 0.
REQ-023 FETCH (1 cycle): o_rd_en=1, o_rd_addr=channel index; -> LOAD.
REQ-024 LOAD (1 cycle): capture i_rd_data into shift register; -> SHIFT.
REQ-025 SHIFT: per bit, MSB first, o_dai valid for 2*CLK_DIV cycles; o_clk low for first CLK_DIV, high for second CLK_DIV.
REQ-026 After BIT_WIDTH bits: if index < N_CHANNELS-1, increment index -> FETCH; else -> LATCH.
REQ-027 LATCH: o_lat=1 for exactly LATCH_CYCLES cycles, o_clk=0, o_dai=0; -> IDLE.
REQ-028 Frame duration SHALL be N_CHANNELS*(2+2*CLK_DIV*BIT_WIDTH)+LATCH_CYCLES cycles from the first FETCH cycle to return to IDLE.
REQ-029 o_clk and o_dai SHALL be 0 outside SHIFT; o_clk SHALL be low during FETCH/LOAD.
REQ-030 A tick while not IDLE SHALL be dropped, pulsing o_overrun for one cycle with o_frame_count unchanged.
REQ-031 A tick coinciding with the LATCH->IDLE transition cycle SHALL count as busy (dropped, overrun).
REQ-032 Deasserting i_enable mid-frame SHALL not abort the frame; only subsequent ticks are suppressed.
REQ-033 o_rd_en, o_lat and o_overrun SHALL be registered outputs; none SHALL glitch.

Reset
REQ-034 i_rst_n=0 SHALL asynchronously force: state IDLE, period counter 0, o_frame_count 0, index 0, shift register 0.
REQ-035 During reset, o_clk, o_dai, o_lat, o_rd_en, o_busy and o_overrun SHALL be 0, and o_rd_addr SHALL be 0.
REQ-036 Reset mid-frame SHALL abandon the frame with no latch; the first tick SHALL occur FRAME_PERIOD-1 cycles after the first active edge after deassertion.

Verification (N_CHANNELS=2, BIT_WIDTH=4, CLK_DIV=1, LATCH_CYCLES=2, FRAME_MAX=3 unless stated)
REQ-037 FRAME_PERIOD=64, data ch0=0xA, ch1=0x5, i_enable=1 -> o_dai bits 1010 then 0101 sampled on o_clk rising edges, 8 o_clk pulses, o_lat high 2 cycles, 22-cycle busy, o_frame_count=1.
REQ-038 FRAME_PERIOD=64, 4 frames -> o_frame_count sequence 1,2,0,1; o_rd_addr 0 then 1 each frame; o_rd_en exactly 2 pulses per frame.
REQ-039 FRAME_PERIOD=16 (less than 22) -> every second tick dropped with a single-cycle o_overrun pulse; o_frame_count advances once per 32 cycles.
REQ-040 i_enable=0 throughout -> o_busy, o_clk, o_lat stay 0; o_frame_count stays 0.
REQ-041 i_rst_n pulsed low during SHIFT of ch1 -> all outputs 0 immediately, no o_lat pulse; next frame starts 63 cycles after release and o_frame_count restarts at 1.
REQ-042 CLK_DIV=3, BIT_WIDTH=1, N_CHANNELS=1, data 1 -> o_dai=1 for 6 cycles, o_clk low 3 then high 3, total busy 1*(2+6)+2=10 cycles.
